// File: rtl/timer_clk_prescaler.sv
// timer_clk_prescaler: count strobe for the 8-bit timer from a pclk divider or a synchronised external event
module timer_clk_prescaler #(
  parameter int SYNC_STAGES = 2,
  parameter bit EXT_EDGE = 1'b0
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en_i,
  input  logic [1:0] cks_i,
  input  logic       ext_sel_i,
  input  logic       ext_clk_i,
  output logic       tick_o,
  output logic [3:0] div_cnt_o
);
  logic [1:0] cks_q;
  logic ext_sel_q;
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic [3:0] n_m1;
  logic cfg_chg, det, wrap;
  assign n_m1 = 4'((5'd2 << cks_i) - 5'd1);
  assign cfg_chg = (cks_i != cks_q) | (ext_sel_i != ext_sel_q);
  assign det = EXT_EDGE ? (~sync[SYNC_STAGES-1] & hist) : (sync[SYNC_STAGES-1] & ~hist);
  assign wrap = div_cnt_o == n_m1;
  // Synchroniser runs even while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cks_q <= 2'b00;
      ext_sel_q <= 1'b0;
      sync <= '0;
      hist <= 1'b0;
      tick_o <= 1'b0;
      div_cnt_o <= 4'd0;
    end else begin
      cks_q <= cks_i;
      ext_sel_q <= ext_sel_i;
      sync <= {sync[SYNC_STAGES-2:0], ext_clk_i};
      hist <= sync[SYNC_STAGES-1];
      if (!en_i || cfg_chg) begin
        tick_o <= 1'b0;
        div_cnt_o <= 4'd0;
      end else if (ext_sel_i) begin
        tick_o <= det;
        div_cnt_o <= 4'd0;
      end else begin
        tick_o <= wrap;
        div_cnt_o <= wrap ? 4'd0 : div_cnt_o + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_timer_clk_prescaler.sv
// tb_timer_clk_prescaler: directed self-checking bench for timer_clk_prescaler
module tb_timer_clk_prescaler;
  logic pclk = 1'b0;
  logic preset, en, ext_sel, ext_clk;
  logic [1:0] cks;
  logic tick0, tick1, tick2;
  logic [3:0] div0, div1, div2;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] cks;
    int n;
    int exp_ticks;
  } mode_t;
  mode_t modes[4];

  always #5 pclk = ~pclk;

  timer_clk_prescaler #(.SYNC_STAGES(2), .EXT_EDGE(1'b0)) dut0 (
    .pclk(pclk), .preset(preset), .en_i(en), .cks_i(cks), .ext_sel_i(ext_sel),
    .ext_clk_i(ext_clk), .tick_o(tick0), .div_cnt_o(div0));
  timer_clk_prescaler #(.SYNC_STAGES(2), .EXT_EDGE(1'b1)) dut1 (
    .pclk(pclk), .preset(preset), .en_i(en), .cks_i(cks), .ext_sel_i(ext_sel),
    .ext_clk_i(ext_clk), .tick_o(tick1), .div_cnt_o(div1));
  timer_clk_prescaler #(.SYNC_STAGES(3), .EXT_EDGE(1'b0)) dut2 (
    .pclk(pclk), .preset(preset), .en_i(en), .cks_i(cks), .ext_sel_i(ext_sel),
    .ext_clk_i(ext_clk), .tick_o(tick2), .div_cnt_o(div2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_div(input int v, output int ok);
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      cyc();
      ok = (int'(div0) == v) ? 1 : 0;
    end
  endtask

  task automatic edges_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      cyc();
      if (tick0) n = i;
    end
  endtask

  initial begin
    int ok, n, cnt, last, bad, mis0, mis1, mis2, c0, c1, c2, divbad;
    bit x, e0, e1, e2;
    modes[0] = '{2'b00, 2, 2048};
    modes[1] = '{2'b01, 4, 1024};
    modes[2] = '{2'b10, 8, 512};
    modes[3] = '{2'b11, 16, 256};
    preset = 1'b1; en = 1'b1; cks = 2'b11; ext_sel = 1'b0; ext_clk = 1'b0;

    // reset held with enable active
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_tick", int'(tick0), 0);
      chk("reset_div", int'(div0), 0);
    end
    preset = 1'b0;
    // cks_q resets to 00, so the first released edge is a config-change edge
    cyc();
    chk("release_div", int'(div0), 0);
    chk("release_tick", int'(tick0), 0);
    edges_to_tick(n);
    chk("first_tick_after_reset", n, 16);

    // free-running divide ratios over 4096 pclk
    foreach (modes[m]) begin
      cks = modes[m].cks;
      cyc();
      chk("cfg_edge_div", int'(div0), 0);
      cnt = 0; last = 0; bad = 0;
      for (int i = 1; i <= 4096; i++) begin
        cyc();
        if (tick0) begin
          cnt++;
          if (i - last != modes[m].n) bad++;
          last = i;
        end
      end
      chk($sformatf("tick_count_cks%0d", m), cnt, modes[m].exp_ticks);
      chk($sformatf("tick_spacing_cks%0d", m), bad, 0);
    end

    // /16 -> /2 switch at div 9
    cks = 2'b11;
    cyc();
    wait_div(9, ok);
    chk("wait_div9", ok, 1);
    cks = 2'b00;
    cyc();
    chk("switch_tick", int'(tick0), 0);
    chk("switch_div", int'(div0), 0);
    cyc();
    chk("switch_p1_tick", int'(tick0), 0);
    chk("switch_p1_div", int'(div0), 1);
    cyc();
    chk("switch_p2_tick", int'(tick0), 1);
    chk("switch_p2_div", int'(div0), 0);
    cyc();
    chk("switch_p3_tick", int'(tick0), 0);

    // disable exactly at terminal count
    cks = 2'b11;
    cyc();
    wait_div(15, ok);
    chk("wait_div15", ok, 1);
    en = 1'b0;
    cyc();
    chk("dis_tick", int'(tick0), 0);
    chk("dis_div", int'(div0), 0);
    repeat (4) cyc();
    chk("dis_hold_div", int'(div0), 0);
    chk("dis_hold_tick", int'(tick0), 0);
    en = 1'b1;
    edges_to_tick(n);
    chk("reenable_first_tick", n, 16);

    // reset mid-count at div 7
    wait_div(7, ok);
    chk("wait_div7", ok, 1);
    preset = 1'b1;
    cyc();
    chk("midreset_div", int'(div0), 0);
    chk("midreset_tick", int'(tick0), 0);
    preset = 1'b0;
    cyc();
    chk("midrelease_div", int'(div0), 0);
    chk("midrelease_tick", int'(tick0), 0);
    edges_to_tick(n);
    chk("midreset_first_tick", n, 16);

    // external events: 10 pulses, 4 high / 4 low; edge k samples the ext value set before it
    ext_sel = 1'b1;
    ext_clk = 1'b0;
    cyc();
    mis0 = 0; mis1 = 0; mis2 = 0; c0 = 0; c1 = 0; c2 = 0; divbad = 0;
    for (int i = 0; i < 90; i++) begin
      x = (i < 80) && ((i % 8) < 4);
      ext_clk = x;
      cyc();
      e0 = (i >= 2) && ((i - 2) % 8 == 0) && (i - 2 < 80);
      e1 = (i >= 6) && ((i - 6) % 8 == 0) && (i - 6 < 80);
      e2 = (i >= 3) && ((i - 3) % 8 == 0) && (i - 3 < 80);
      if (tick0 != e0) mis0++;
      if (tick1 != e1) mis1++;
      if (tick2 != e2) mis2++;
      if (tick0) c0++;
      if (tick1) c1++;
      if (tick2) c2++;
      if (div0 != 4'd0 || div1 != 4'd0 || div2 != 4'd0) divbad++;
    end
    chk("ext_rise_timing", mis0, 0);
    chk("ext_rise_count", c0, 10);
    chk("ext_fall_timing", mis1, 0);
    chk("ext_fall_count", c1, 10);
    chk("ext_sync3_timing", mis2, 0);
    chk("ext_sync3_count", c2, 10);
    chk("ext_div_held", divbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_clk_prescaler.md
Name: timer_clk_prescaler

Overview:
Count-enable generator directly upstream of the 8-bit timer counter. Turns the TCR enable and clock-select fields into a single-pclk-wide tick_o that the counter uses as its clk_in increment/decrement strobe. Source is either an internal divide-by-2/4/8/16 of pclk or a synchronised, edge-detected external event input. The timer's count-up/count-down overflow timing (for example, 256 ticks in 4096 pclk at clk16) is defined entirely by this block.

Parameters:
SYNC_STAGES, 2, synchroniser depth on ext_clk_i; legal values 2 or 3.
EXT_EDGE, 0, external edge that produces a tick: 0 = rising, 1 = falling.

Ports:
pclk  input  1  system/APB clock; all logic is on its rising edge.
preset  input  1  synchronous active-high reset.
en_i  input  1  timer enable (TCR.en).
cks_i  input  2  clock select (TCR.cks): 00 = /2, 01 = /4, 10 = /8, 11 = /16.
ext_sel_i  input  1  1 = external event source, 0 = internal divider.
ext_clk_i  input  1  asynchronous external event pin.
tick_o  output  1  registered count strobe, high for exactly one pclk.
div_cnt_o  output  4  current divider count (debug/observability).

Behaviour:
- Interface: one clock, pclk. Reset preset is synchronous and active-high.
- Reset values: tick_o = 0, div_cnt_o = 0, all synchroniser and edge flops = 0, cks_q = 00, ext_sel_q = 0.
- Divide ratio: N = 2 << cks_i (2, 4, 8, 16). div_cnt is 4 bits wide and wraps from N-1 to 0.
- Internal mode (en_i = 1, ext_sel_i = 0):
  - div_cnt increments every pclk.
  - tick_o <= (div_cnt == N-1). div_cnt wraps to 0 on that same edge.
  - First tick_o is high in the cycle after the N-th edge at which en_i is sampled 1.
  - After that, tick_o is high for 1 cycle in every N; duty is 1/N.
- External mode (en_i = 1, ext_sel_i = 1):
  - ext_clk_i passes through SYNC_STAGES flops plus one history flop.
  - Rising detect: sync_last & ~hist. Falling detect: ~sync_last & hist. tick_o <= the selected detect.
  - Latency: SYNC_STAGES+1 pclk edges from the edge that first samples the transition (3 for the default).
  - div_cnt is held at 0 in this mode.
  - Pulses shorter than 1 pclk may be lost. Events faster than 1 per 2 pclk are not guaranteed.
- Disabled (en_i = 0):
  - div_cnt <= 0 and tick_o <= 0 on the next edge.
  - Synchronisers keep sampling, so a later enable does not produce a spurious stale edge.
  - Re-enabling restarts a full N-cycle period.
- Configuration change:
  - cks_q and ext_sel_q register their inputs every cycle.
  - If cks_i != cks_q or ext_sel_i != ext_sel_q: div_cnt <= 0 and tick_o <= 0 that cycle.
  - A full new period starts from the next cycle. No shortened or merged tick is permitted.
- Simultaneous cases:
  - Config change on the same cycle as div_cnt == N-1: the change wins, no tick.
  - en_i falling on the same cycle as div_cnt == N-1: no tick.
- Reset mid-operation (preset high): on that edge all state returns to reset values, regardless of en_i. The first tick after release follows the rules above.
- tick_o never asserts on two consecutive cycles in internal mode.

Test Plan:
1. Reset: preset=1 for 3 cycles with en_i=1, cks_i=11 -> tick_o=0, div_cnt_o=0 throughout. After release, the first tick arrives 16 edges later.
2. cks_i=11, en_i=1, ext_sel_i=0 for 4096 pclk -> exactly 256 tick_o pulses spaced 16 cycles apart. Repeat for cks 00/01/10 -> 2048/1024/512 pulses at 2/4/8-cycle spacing.
3. Running at /16, change cks_i to 00 when div_cnt_o=9 -> no tick that cycle, div_cnt_o=0 next cycle. First /2 tick 2 cycles later, none merged.
4. en_i dropped when div_cnt_o=15 -> no tick, div_cnt_o=0. Re-enable 5 cycles later -> first tick 16 cycles after re-enable.
5. ext_sel_i=1, EXT_EDGE=0, SYNC_STAGES=2, drive 10 ext_clk_i pulses of 4 pclk high / 4 low -> 10 single-cycle ticks, each 3 edges after its rising sample, div_cnt_o=0. EXT_EDGE=1 -> ticks on the falling edges instead.
6. preset asserted mid-count at div_cnt_o=7 (/16 mode) -> div_cnt_o=0 next cycle, tick_o stays 0. Next tick 16 cycles after release.
